// File: rtl/apb_xip_cache.sv
// Direct-mapped, one-word-per-line read cache in front of the SPI/XIP APB bridge.
// Flash-window read hits are answered locally; everything else except flash writes is forwarded.
module apb_xip_cache #(
  parameter logic [31:0] FLASH_BASE = 32'h3000_0000,
  parameter logic [31:0] FLASH_SIZE = 32'h1000_0000,
  parameter int          LINES      = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_paddr,
  input  logic        in_psel,
  input  logic        in_penable,
  input  logic [2:0]  in_pprot,
  input  logic        in_pwrite,
  input  logic [31:0] in_pwdata,
  input  logic [3:0]  in_pstrb,
  output logic        in_pready,
  output logic [31:0] in_prdata,
  output logic        in_pslverr,
  output logic [31:0] out_paddr,
  output logic        out_psel,
  output logic        out_penable,
  output logic [2:0]  out_pprot,
  output logic        out_pwrite,
  output logic [31:0] out_pwdata,
  output logic [3:0]  out_pstrb,
  input  logic        out_pready,
  input  logic [31:0] out_prdata,
  input  logic        out_pslverr,
  input  logic        cache_flush,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t      r_state;
  logic [31:0] r_addr, r_wdata;
  logic        r_write;
  logic [3:0]  r_strb;
  logic [2:0]  r_prot;
  logic        r_pready, r_pslverr, r_opsel, r_openable;
  logic [31:0] r_prdata, r_hit_cnt, r_miss_cnt;
  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [31:0]      r_data [LINES];

  logic             w_in_win, w_cacheable, w_flash_wr, w_hit, w_fill;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;

  // Offset compare keeps the window check correct even if it ends at the top of the address map.
  assign w_in_win    = (r_addr >= FLASH_BASE) && ((r_addr - FLASH_BASE) < FLASH_SIZE);
  assign w_cacheable = !r_write && w_in_win;
  assign w_flash_wr  = r_write && w_in_win;
  assign w_idx       = r_addr[2 +: IDX_W];
  assign w_tag       = r_addr[31 -: TAG_W];
  assign w_hit       = w_cacheable && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_fill      = (r_state == S_ACCESS) && out_pready && w_cacheable && !out_pslverr;

  assign in_pready   = r_pready;
  assign in_prdata   = r_prdata;
  assign in_pslverr  = r_pslverr;
  assign out_paddr   = r_addr;
  assign out_psel    = r_opsel;
  assign out_penable = r_openable;
  assign out_pprot   = r_prot;
  assign out_pwrite  = r_write;
  assign out_pwdata  = r_wdata;
  assign out_pstrb   = r_strb;
  assign hit_cnt     = r_hit_cnt;
  assign miss_cnt    = r_miss_cnt;

  always_ff @(posedge clock) begin
    if (w_fill) begin
      r_tag[w_idx]  <= w_tag;
      r_data[w_idx] <= out_prdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_write    <= 1'b0;
      r_strb     <= '0;
      r_prot     <= '0;
      r_pready   <= 1'b0;
      r_pslverr  <= 1'b0;
      r_prdata   <= '0;
      r_opsel    <= 1'b0;
      r_openable <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_valid    <= '0;
    end else begin
      // A flush landing on the fill cycle wins, so the filled line stays invalid.
      if (cache_flush)
        r_valid <= '0;
      else if (w_fill)
        r_valid[w_idx] <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (in_psel && in_penable) begin
            r_addr  <= in_paddr;
            r_write <= in_pwrite;
            r_wdata <= in_pwdata;
            r_strb  <= in_pstrb;
            r_prot  <= in_pprot;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_hit) begin
            r_prdata  <= r_data[w_idx];
            r_pslverr <= 1'b0;
            r_pready  <= 1'b1;
            if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 32'd1;
            r_state   <= S_RESP;
          end else if (w_flash_wr) begin
            r_prdata  <= '0;
            r_pslverr <= 1'b1;
            r_pready  <= 1'b1;
            r_state   <= S_RESP;
          end else begin
            if (w_cacheable && r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 32'd1;
            r_opsel <= 1'b1;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_openable <= 1'b1;
          r_state    <= S_ACCESS;
        end
        S_ACCESS: begin
          if (out_pready) begin
            r_prdata   <= out_prdata;
            r_pslverr  <= out_pslverr;
            r_opsel    <= 1'b0;
            r_openable <= 1'b0;
            r_pready   <= 1'b1;
            r_state    <= S_RESP;
          end
        end
        S_RESP: begin
          r_pready <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_xip_cache.sv
// Directed bench for apb_xip_cache: APB master, bridge model and a word-address cache model.
module tb_apb_xip_cache;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] in_paddr, in_pwdata, in_prdata;
  logic        in_psel, in_penable, in_pwrite, in_pready, in_pslverr;
  logic [2:0]  in_pprot;
  logic [3:0]  in_pstrb;
  logic [31:0] out_paddr, out_pwdata, out_prdata;
  logic        out_psel, out_penable, out_pwrite, out_pready, out_pslverr;
  logic [2:0]  out_pprot;
  logic [3:0]  out_pstrb;
  logic        cache_flush, flush_req, fill_flush;
  logic [31:0] hit_cnt, miss_cnt;

  int checks = 0, failures = 0;

  always #5 clock = ~clock;
  assign cache_flush = flush_req | fill_flush;

  apb_xip_cache dut (
    .clock(clock), .reset(reset),
    .in_paddr(in_paddr), .in_psel(in_psel), .in_penable(in_penable), .in_pprot(in_pprot),
    .in_pwrite(in_pwrite), .in_pwdata(in_pwdata), .in_pstrb(in_pstrb),
    .in_pready(in_pready), .in_prdata(in_prdata), .in_pslverr(in_pslverr),
    .out_paddr(out_paddr), .out_psel(out_psel), .out_penable(out_penable), .out_pprot(out_pprot),
    .out_pwrite(out_pwrite), .out_pwdata(out_pwdata), .out_pstrb(out_pstrb),
    .out_pready(out_pready), .out_prdata(out_prdata), .out_pslverr(out_pslverr),
    .cache_flush(cache_flush), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Bridge model: answers after br_wait access cycles, records each forwarded setup phase.
  int          br_wait = 1, br_cnt = 0, fwd_cnt = 0;
  logic [31:0] br_rdata = '0;
  logic        br_err = 1'b0, br_flush = 1'b0;
  logic [31:0] cap_addr, cap_wdata;
  logic        cap_write;
  logic [3:0]  cap_strb;
  logic [2:0]  cap_prot;

  initial begin
    out_pready = 1'b0; out_prdata = '0; out_pslverr = 1'b0; fill_flush = 1'b0;
  end

  always @(negedge clock) begin
    if (out_psel && !out_penable) begin
      fwd_cnt++;
      cap_addr = out_paddr; cap_wdata = out_pwdata; cap_write = out_pwrite;
      cap_strb = out_pstrb; cap_prot = out_pprot;
    end
    if (out_psel && out_penable) br_cnt++; else br_cnt = 0;
    out_pready  = out_psel && out_penable && (br_cnt == br_wait);
    out_prdata  = out_pready ? br_rdata : 32'h0;
    out_pslverr = out_pready ? br_err : 1'b0;
    fill_flush  = out_pready && br_flush;
  end

  // While a locally answered request is in flight the bridge must see nothing.
  logic no_fwd = 1'b0;
  always @(negedge clock) begin
    if (no_fwd) chk("no_out_psel", {31'b0, out_psel}, 32'h0);
  end

  // Cache model keyed by word address; lines selected by word address modulo 16.
  bit          m_vld [16];
  logic [29:0] m_word[16];
  logic [31:0] m_dat [16];
  logic [31:0] m_hits = '0, m_miss = '0;

  function automatic bit in_flash(input logic [31:0] a);
    return (a >= 32'h3000_0000) && (a < 32'h4000_0000);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_vld[i] = 1'b0;
  endtask

  task automatic xfer(input string name, input logic [31:0] addr, input bit wr,
                      input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                      input logic [31:0] rdata, input bit err, input int wait_c,
                      input bit flush_fill, input int setup_cyc);
    logic [31:0] exp_data;
    bit exp_err, exp_fwd;
    int exp_lat, lat, f0, idx;
    idx = int'((addr >> 2) % 16);
    if (!wr && in_flash(addr) && m_vld[idx] && m_word[idx] == addr[31:2]) begin
      exp_data = m_dat[idx]; exp_err = 0; exp_lat = 2; exp_fwd = 0; m_hits++;
    end else if (wr && in_flash(addr)) begin
      exp_data = 0; exp_err = 1; exp_lat = 2; exp_fwd = 0;
    end else begin
      exp_data = rdata; exp_err = err; exp_lat = 3 + wait_c; exp_fwd = 1;
      if (!wr && in_flash(addr)) begin
        m_miss++;
        if (!err) begin m_vld[idx] = 1; m_word[idx] = addr[31:2]; m_dat[idx] = rdata; end
      end
      if (flush_fill) model_clear();
    end
    br_wait = wait_c; br_rdata = rdata; br_err = err; br_flush = flush_fill;
    @(negedge clock);
    in_paddr = addr; in_pwrite = wr; in_pwdata = wdata; in_pstrb = strb; in_pprot = prot;
    in_psel = 1; in_penable = 0;
    for (int i = 1; i < setup_cyc; i++) @(negedge clock);
    no_fwd = !exp_fwd;
    f0 = fwd_cnt;
    @(negedge clock);
    in_penable = 1;
    lat = 0;
    while (1) begin
      @(negedge clock);
      lat++;
      if (in_pready) break;
      if (lat > 60) begin
        failures++;
        $display("FAIL %s_timeout actual=no_pready expected=pready", name);
        break;
      end
    end
    in_psel = 0; in_penable = 0;
    chk({name, "_lat"}, lat, exp_lat);
    chk({name, "_data"}, in_prdata, exp_data);
    chk({name, "_err"}, {31'b0, in_pslverr}, {31'b0, exp_err});
    chk({name, "_fwd"}, fwd_cnt - f0, {31'b0, exp_fwd});
    chk({name, "_hits"}, hit_cnt, m_hits);
    chk({name, "_miss"}, miss_cnt, m_miss);
    if (exp_fwd) begin
      chk({name, "_fwd_addr"}, cap_addr, addr);
      chk({name, "_fwd_ctl"}, {23'b0, cap_write, cap_strb, cap_prot}, {23'b0, wr, strb, prot});
      if (wr) chk({name, "_fwd_wdata"}, cap_wdata, wdata);
    end
    no_fwd = 0;
    br_flush = 0;
    @(negedge clock);
    chk({name, "_pulse"}, {31'b0, in_pready}, 32'h0);
    chk({name, "_hold"}, in_prdata, exp_data);
  endtask

  task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] rdata,
                    input int wait_c);
    xfer(name, addr, 0, 32'h0, 4'hF, 3'b000, rdata, 0, wait_c, 0, 1);
  endtask

  initial begin
    reset = 1; flush_req = 0;
    in_paddr = '0; in_psel = 0; in_penable = 0; in_pprot = '0; in_pwrite = 0;
    in_pwdata = '0; in_pstrb = '0;
    model_clear();
    repeat (2) @(negedge clock);
    chk("rst_outs", {29'b0, in_pready, in_pslverr, out_psel | out_penable | out_pwrite},
        32'h0);
    chk("rst_prdata", in_prdata, 32'h0);
    chk("rst_out_paddr", out_paddr, 32'h0);
    chk("rst_cnts", hit_cnt | miss_cnt, 32'h0);
    reset = 0;

    rd("cold", 32'h3000_0010, 32'hDEAD_BEEF, 5);
    chk("cold_lit_data", in_prdata, 32'hDEAD_BEEF);
    chk("cold_lit_miss", miss_cnt, 32'd1);
    rd("warm", 32'h3000_0010, 32'h0BAD_0BAD, 1);
    chk("warm_lit_hit", hit_cnt, 32'd1);
    chk("warm_lit_data", in_prdata, 32'hDEAD_BEEF);

    rd("alias_a", 32'h3000_0050, 32'h1111_2222, 1);
    rd("alias_b", 32'h3000_0010, 32'h3333_4444, 2);
    chk("alias_lit_miss", miss_cnt, 32'd3);
    rd("alias_c", 32'h3000_0050, 32'h5555_6666, 1);
    rd("alias_d", 32'h3000_0010, 32'h7777_8888, 1);

    xfer("fwr", 32'h3000_0000, 1, 32'h1234_5678, 4'hF, 3'b001, 32'h0, 0, 1, 0, 1);
    chk("fwr_lit_err", {31'b0, in_pslverr}, 32'h1);
    xfer("nwr", 32'h1000_1000, 1, 32'hCAFE_F00D, 4'b0101, 3'b010, 32'h0, 0, 3, 0, 1);
    chk("nwr_lit_addr", cap_addr, 32'h1000_1000);

    xfer("err1", 32'h3000_0100, 0, 32'h0, 4'hF, 3'b000, 32'hE0E0_E0E0, 1, 2, 0, 1);
    chk("err1_lit", {31'b0, in_pslverr}, 32'h1);
    rd("err2", 32'h3000_0100, 32'hAAAA_0100, 1);
    rd("err3", 32'h3000_0100, 32'hFFFF_FFFF, 1);

    rd("top_a", 32'h3FFF_FFFC, 32'h0F0F_0F0F, 1);
    rd("top_b", 32'h3FFF_FFFC, 32'h0, 1);
    rd("above_a", 32'h4000_0000, 32'h4444_0000, 1);
    rd("above_b", 32'h4000_0000, 32'h4444_0001, 2);
    rd("below_a", 32'h2FFF_FFFC, 32'h2222_FFFC, 1);
    rd("below_b", 32'h2FFF_FFFC, 32'h2222_FFFD, 1);
    xfer("setup3", 32'h3FFF_FFFC, 0, 32'h0, 4'hF, 3'b000, 32'h0, 0, 1, 0, 3);

    rd("fl_warm", 32'h3000_0020, 32'h2020_2020, 1);
    rd("fl_hit", 32'h3000_0020, 32'h0, 1);
    @(negedge clock); flush_req = 1;
    @(negedge clock); flush_req = 0;
    model_clear();
    rd("fl_after", 32'h3000_0020, 32'h2121_2121, 1);
    rd("fl_other", 32'h3000_0050, 32'h5050_5050, 1);
    xfer("ff_fill", 32'h3000_0030, 0, 32'h0, 4'hF, 3'b000, 32'h3030_3030, 0, 2, 1, 1);
    rd("ff_again", 32'h3000_0030, 32'h3131_3131, 1);
    rd("ff_other", 32'h3000_0050, 32'h5151_5151, 1);

    rd("rs_warm", 32'h3000_0040, 32'h4040_4040, 1);
    rd("rs_hit", 32'h3000_0040, 32'h0, 1);
    br_wait = 30; br_rdata = 32'h8080_8080; br_err = 0;
    @(negedge clock);
    in_paddr = 32'h3000_0080; in_pwrite = 0; in_psel = 1; in_penable = 0;
    @(negedge clock); in_penable = 1;
    repeat (5) @(negedge clock);
    chk("rs_in_access", {30'b0, out_psel, out_penable}, 32'h3);
    reset = 1; in_psel = 0; in_penable = 0;
    @(negedge clock);
    chk("rs_out_idle", {29'b0, out_psel, out_penable, in_pready}, 32'h0);
    chk("rs_cnts", hit_cnt | miss_cnt, 32'h0);
    reset = 0;
    model_clear(); m_hits = 0; m_miss = 0;
    rd("rs_after", 32'h3000_0040, 32'h4141_4141, 1);
    chk("rs_lit_miss", miss_cnt, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
